// File: rtl/load_dispatcher_if.sv
// Aggregator-to-dispatcher link: packed words in, pack permission and fetch-width programming out.
// in_enq is the per-cycle valid of in_data and is not gated by in_full_n; in_full_n only tells the
// aggregator it may pack/dequeue, and it drops combinationally while the last element of a phase is enqueued.
interface load_dispatcher_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 6
);
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_data;
  logic                              in_enq;
  logic                              in_full_n;
  logic                              agg_change_fetch_width;
  logic [2:0]                        agg_fetch_width;

  modport master (
    output in_data, in_enq,
    input  in_full_n, agg_change_fetch_width, agg_fetch_width
  );

  modport slave (
    input  in_data, in_enq,
    output in_full_n, agg_change_fetch_width, agg_fetch_width
  );
endinterface

// File: rtl/load_dispatcher.sv
// Streams aggregator words into the node, leaf and query memories in fixed order and reprograms
// the aggregator fetch width with a one-cycle switch state between phases.
module load_dispatcher #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 6,
  parameter int NODE_FW     = 2,
  parameter int PATCH_FW    = 5,
  parameter int NUM_NODES   = 31,
  parameter int NUM_LEAVES  = 32,
  parameter int LEAF_SIZE   = 8,
  parameter int NUM_QUERIES = 1024,
  localparam int NODE_AW  = (NUM_NODES   > 1) ? $clog2(NUM_NODES)   : 1,
  localparam int LEAF_AW  = (NUM_LEAVES  > 1) ? $clog2(NUM_LEAVES)  : 1,
  localparam int SLOT_W   = (LEAF_SIZE   > 1) ? $clog2(LEAF_SIZE)   : 1,
  localparam int QUERY_AW = (NUM_QUERIES > 1) ? $clog2(NUM_QUERIES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  load_dispatcher_if.slave               agg,
  output logic                           node_wen,
  output logic [NODE_AW-1:0]             node_addr,
  output logic [NODE_FW*DATA_WIDTH-1:0]  node_wdata,
  output logic                           leaf_wen,
  output logic [LEAF_AW-1:0]             leaf_addr,
  output logic [SLOT_W-1:0]              leaf_slot,
  output logic [PATCH_FW*DATA_WIDTH-1:0] leaf_wdata,
  output logic                           query_wen,
  output logic [QUERY_AW-1:0]            query_addr,
  output logic [PATCH_FW*DATA_WIDTH-1:0] query_wdata,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     state_dbg
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SW_NODE  = 3'd1;
  localparam logic [2:0] S_NODES    = 3'd2;
  localparam logic [2:0] S_SW_LEAF  = 3'd3;
  localparam logic [2:0] S_LEAVES   = 3'd4;
  localparam logic [2:0] S_SW_QUERY = 3'd5;
  localparam logic [2:0] S_QUERIES  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]          state;
  logic [NODE_AW-1:0]  node_cnt;
  logic [LEAF_AW-1:0]  leaf_cnt;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [QUERY_AW-1:0] query_cnt;
  logic                in_load;
  logic                last;
  logic                slot_wrap;

  assign in_load   = (state == S_NODES) || (state == S_LEAVES) || (state == S_QUERIES);
  assign slot_wrap = (slot_cnt == SLOT_W'(LEAF_SIZE - 1));

  always_comb begin
    last = 1'b0;
    case (state)
      S_NODES:   last = (node_cnt == NODE_AW'(NUM_NODES - 1));
      S_LEAVES:  last = (leaf_cnt == LEAF_AW'(NUM_LEAVES - 1)) && slot_wrap;
      S_QUERIES: last = (query_cnt == QUERY_AW'(NUM_QUERIES - 1));
      default:   last = 1'b0;
    endcase
  end

  // Blocking the final accept cycle keeps the aggregator from packing a word under the old width.
  assign agg.in_full_n              = in_load && !(agg.in_enq && last);
  assign agg.agg_change_fetch_width = (state == S_SW_NODE) || (state == S_SW_LEAF) || (state == S_SW_QUERY);
  assign agg.agg_fetch_width        = (state == S_SW_NODE) ? 3'(NODE_FW) :
                                      ((state == S_SW_LEAF) || (state == S_SW_QUERY)) ? 3'(PATCH_FW) : 3'd0;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  generate
    if (FETCH_WIDTH > PATCH_FW) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^agg.in_data[FETCH_WIDTH*DATA_WIDTH-1:PATCH_FW*DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      node_cnt    <= '0;
      leaf_cnt    <= '0;
      slot_cnt    <= '0;
      query_cnt   <= '0;
      node_wen    <= 1'b0;
      node_addr   <= '0;
      node_wdata  <= '0;
      leaf_wen    <= 1'b0;
      leaf_addr   <= '0;
      leaf_slot   <= '0;
      leaf_wdata  <= '0;
      query_wen   <= 1'b0;
      query_addr  <= '0;
      query_wdata <= '0;
    end else begin
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;
      query_wen <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_SW_NODE;
            node_cnt  <= '0;
            leaf_cnt  <= '0;
            slot_cnt  <= '0;
            query_cnt <= '0;
          end
        end
        S_SW_NODE:  state <= S_NODES;
        S_SW_LEAF:  state <= S_LEAVES;
        S_SW_QUERY: state <= S_QUERIES;
        S_NODES: begin
          if (agg.in_enq) begin
            node_wen   <= 1'b1;
            node_addr  <= node_cnt;
            node_wdata <= agg.in_data[NODE_FW*DATA_WIDTH-1:0];
            node_cnt   <= node_cnt + 1'b1;
            if (last) state <= S_SW_LEAF;
          end
        end
        S_LEAVES: begin
          if (agg.in_enq) begin
            leaf_wen   <= 1'b1;
            leaf_addr  <= leaf_cnt;
            leaf_slot  <= slot_cnt;
            leaf_wdata <= agg.in_data[PATCH_FW*DATA_WIDTH-1:0];
            if (slot_wrap) begin
              slot_cnt <= '0;
              leaf_cnt <= leaf_cnt + 1'b1;
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
            if (last) state <= S_SW_QUERY;
          end
        end
        S_QUERIES: begin
          if (agg.in_enq) begin
            query_wen   <= 1'b1;
            query_addr  <= query_cnt;
            query_wdata <= agg.in_data[PATCH_FW*DATA_WIDTH-1:0];
            query_cnt   <= query_cnt + 1'b1;
            if (last) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_dispatcher.sv
// Directed bench for load_dispatcher on a reduced tree: 3 nodes, 2 leaves x 2 slots, 4 queries.
module tb_load_dispatcher;

  localparam int DW = 16;
  localparam int FW = 6;

  // Expected state encodings in the listed order IDLE..DONE.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SW_LEAF = 3'd3;
  localparam logic [2:0] ST_SW_QUERY = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       node_wen, leaf_wen, query_wen, busy, done;
  logic [1:0] node_addr, query_addr;
  logic [0:0] leaf_addr, leaf_slot;
  logic [31:0] node_wdata;
  logic [79:0] leaf_wdata, query_wdata;
  logic [2:0] state_dbg;

  load_dispatcher_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) agg ();

  load_dispatcher #(
    .DATA_WIDTH(DW), .FETCH_WIDTH(FW), .NODE_FW(2), .PATCH_FW(5),
    .NUM_NODES(3), .NUM_LEAVES(2), .LEAF_SIZE(2), .NUM_QUERIES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .agg(agg),
    .node_wen(node_wen), .node_addr(node_addr), .node_wdata(node_wdata),
    .leaf_wen(leaf_wen), .leaf_addr(leaf_addr), .leaf_slot(leaf_slot), .leaf_wdata(leaf_wdata),
    .query_wen(query_wen), .query_addr(query_addr), .query_wdata(query_wdata),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [97:0] pack(logic [1:0] k, logic [7:0] a, logic [7:0] s, logic [79:0] d);
    return {k, a, s, d};
  endfunction

  typedef struct {
    logic [95:0] din;
    int          gap;
    logic [1:0]  kind;      // 1 node, 2 leaf, 3 query
    logic [7:0]  addr;
    logic [7:0]  slot;
    logic [79:0] dexp;
    logic        last;
    logic        start_too;
    logic        rogue_after;
  } vec_t;

  vec_t vecs[11];

  // scoreboard
  logic [97:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [2:0]  width_q[$];
  int          run_q[$];
  int          run_len = 0;

  always @(negedge clk) begin
    int nw;
    logic [97:0] act;
    nw = int'(node_wen) + int'(leaf_wen) + int'(query_wen);
    act = '0;
    if (nw > 1) check("one_wen", 128'(nw), 128'd1);
    if (nw != 0) begin
      if (node_wen)       act = pack(2'd1, 8'(node_addr), 8'd0, 80'(node_wdata));
      else if (leaf_wen)  act = pack(2'd2, 8'(leaf_addr), 8'(leaf_slot), leaf_wdata);
      else                act = pack(2'd3, 8'(query_addr), 8'd0, query_wdata);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 128'(act), 128'd0);
      end else begin
        check("write", 128'(act), 128'(exp_q.pop_front()));
        check("write_latency", 128'(cyc), 128'(exp_cyc_q.pop_front()));
      end
    end
    if (agg.agg_change_fetch_width) begin
      width_q.push_back(agg.agg_fetch_width);
      check("sw_full_n", 128'(agg.in_full_n), 128'd0);
    end
    if (busy && !agg.in_full_n) begin
      run_len++;
    end else begin
      if (run_len > 0 && agg.in_full_n) run_q.push_back(run_len);
      run_len = 0;
    end
  end

  // driver tasks; every task is entered and left 2 time units after a rising edge
  task automatic rogue_enq();
    agg.in_enq = 1'b1;
    agg.in_data = 96'hdead_beef_dead_beef_dead_beef;
    @(posedge clk); #2;
    agg.in_enq = 1'b0;
    agg.in_data = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    #1;
    check("start_busy", 128'(busy), 128'd1);
    check("start_done", 128'(done), 128'd0);
    check("start_full_n", 128'(agg.in_full_n), 128'd0);
    check("start_change", 128'(agg.agg_change_fetch_width), 128'd1);
    check("start_width", 128'(agg.agg_fetch_width), 128'd2);
    @(posedge clk); #3;
    check("start_full_n_t2", 128'(agg.in_full_n), 128'd1);
    @(posedge clk); #2;
  endtask

  task automatic apply_vec(input int i, input bit rand_gaps);
    int gap;
    int budget;
    gap = rand_gaps ? int'($urandom_range(0, 5)) : vecs[i].gap;
    repeat (gap) begin
      @(posedge clk); #2;
    end
    agg.in_enq = 1'b0;
    #1;
    budget = 0;
    while (!agg.in_full_n && budget < 50) begin
      @(posedge clk); #3;
      budget++;
    end
    if (budget >= 50) begin
      check("full_n_timeout", 128'(budget), 128'd0);
      @(posedge clk); #2;
      return;
    end
    if (vecs[i].start_too) start = 1'b1;
    agg.in_data = vecs[i].din;
    agg.in_enq = 1'b1;
    #1;
    check("full_n_last", 128'(agg.in_full_n), 128'(!vecs[i].last));
    exp_q.push_back(pack(vecs[i].kind, vecs[i].addr, vecs[i].slot, vecs[i].dexp));
    exp_cyc_q.push_back(cyc + 1);
    @(posedge clk); #2;
    agg.in_enq = 1'b0;
    agg.in_data = '0;
    start = 1'b0;
    if (vecs[i].last) begin
      #1;
      case (vecs[i].kind)
        2'd1:    check("boundary_state", 128'(state_dbg), 128'(ST_SW_LEAF));
        2'd2:    check("boundary_state", 128'(state_dbg), 128'(ST_SW_QUERY));
        default: begin
          check("boundary_state", 128'(state_dbg), 128'(ST_DONE));
          check("done_after_last", 128'(done), 128'd1);
          check("busy_after_last", 128'(busy), 128'd0);
        end
      endcase
    end
    if (vecs[i].rogue_after) rogue_enq();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 128'(state_dbg), 128'(ST_IDLE));
    check({tag, "_flags"}, 128'({busy, done, agg.in_full_n, agg.agg_change_fetch_width}), 128'd0);
    check({tag, "_width"}, 128'(agg.agg_fetch_width), 128'd0);
    check({tag, "_wen"}, 128'({node_wen, leaf_wen, query_wen}), 128'd0);
    check({tag, "_addr"}, 128'({node_addr, leaf_addr, leaf_slot, query_addr}), 128'd0);
    check({tag, "_wdata"}, 128'(node_wdata | leaf_wdata[31:0] | query_wdata[31:0]), 128'd0);
    check({tag, "_wdata_hi"}, 128'(leaf_wdata | query_wdata), 128'd0);
  endtask

  task automatic check_phase_log();
    check("pulse_count", 128'(width_q.size()), 128'd3);
    if (width_q.size() == 3) begin
      check("width0", 128'(width_q[0]), 128'd2);
      check("width1", 128'(width_q[1]), 128'd5);
      check("width2", 128'(width_q[2]), 128'd5);
    end
    check("block_runs", 128'(run_q.size()), 128'd3);
    if (run_q.size() == 3) begin
      check("block_run_start", 128'(run_q[0]), 128'd1);
      check("block_run_leaf", 128'(run_q[1]), 128'd2);
      check("block_run_query", 128'(run_q[2]), 128'd2);
    end
  endtask

  task automatic clear_log();
    width_q.delete();
    run_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            din                               gap kind addr slot dexp                          last st  rogue
    vecs[0]  = '{96'hffff_ffff_ffff_ffff_0001_0002, 0, 2'd1, 8'd0, 8'd0, 80'h0001_0002,              1'b0, 1'b0, 1'b0};
    vecs[1]  = '{96'h1234_5678_9abc_def0_aaaa_5555, 0, 2'd1, 8'd1, 8'd0, 80'haaaa_5555,              1'b0, 1'b1, 1'b0};
    vecs[2]  = '{96'h0000_0000_0000_0000_8000_0001, 2, 2'd1, 8'd2, 8'd0, 80'h8000_0001,              1'b1, 1'b0, 1'b1};
    vecs[3]  = '{96'hbeef_1111_2222_3333_4444_5555, 0, 2'd2, 8'd0, 8'd0, 80'h1111_2222_3333_4444_5555, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{96'h0000_ffff_0000_ffff_0000_ffff, 0, 2'd2, 8'd0, 8'd1, 80'hffff_0000_ffff_0000_ffff, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{96'hcafe_0101_0202_0303_0404_0505, 3, 2'd2, 8'd1, 8'd0, 80'h0101_0202_0303_0404_0505, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{96'h7777_8888_9999_aaaa_bbbb_cccc, 0, 2'd2, 8'd1, 8'd1, 80'h8888_9999_aaaa_bbbb_cccc, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{96'h0000_1000_2000_3000_4000_5000, 0, 2'd3, 8'd0, 8'd0, 80'h1000_2000_3000_4000_5000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{96'hffff_0fff_1fff_2fff_3fff_4fff, 1, 2'd3, 8'd1, 8'd0, 80'h0fff_1fff_2fff_3fff_4fff, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{96'h0101_a5a5_5a5a_a5a5_5a5a_a5a5, 0, 2'd3, 8'd2, 8'd0, 80'ha5a5_5a5a_a5a5_5a5a_a5a5, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{96'h9999_0000_0000_0000_0000_0001, 0, 2'd3, 8'd3, 8'd0, 80'h0000_0000_0000_0000_0001, 1'b1, 1'b0, 1'b1};

    // reset block
    rst_n = 1'b0;
    start = 1'b0;
    agg.in_enq = 1'b0;
    agg.in_data = '0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_values("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // enq while idle must not write
    rogue_enq();

    // full load with directed gaps, start pulse in NODES, rogue enqs in SW_LEAF/SW_QUERY/DONE
    clear_log();
    do_start();
    for (int i = 0; i < 11; i++) apply_vec(i, 1'b0);
    repeat (2) begin
      @(posedge clk); #2;
    end
    check("run1_drained", 128'(exp_q.size()), 128'd0);
    check_phase_log();

    // restart from DONE, random gaps, reset in the middle of LEAVES
    clear_log();
    do_start();
    for (int i = 0; i < 5; i++) apply_vec(i, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check_reset_values("midreset");
    check("midreset_drained", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #2;

    // fresh load after mid-phase reset restarts at node 0
    clear_log();
    do_start();
    for (int i = 0; i < 11; i++) apply_vec(i, 1'b1);
    repeat (3) begin
      @(posedge clk); #2;
    end
    check("run3_drained", 128'(exp_q.size()), 128'd0);
    check_phase_log();
    check("final_done", 128'(done), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_dispatcher.md
# load_dispatcher

Consumes packed wide words straight from the aggregator output (no FIFO between them) and writes them into the kd-tree internal-node, leaf-patch and query-patch memories in a fixed load order. It also owns the aggregator's fetch-width programming: it throttles the aggregator around every phase boundary so that no word is packed with a stale width. It sits between the input aggregator and the on-chip tree/query storage, and signals completion to the top-level controller.

## Interface
- DATA_WIDTH, 16, width of one narrow word
- FETCH_WIDTH, 6, max words per packed aggregator word
- NODE_FW, 2, words per internal node (word0 = split dim, word1 = median)
- PATCH_FW, 5, words per leaf or query patch
- NUM_NODES, 31, internal nodes to load
- NUM_LEAVES, 32, leaves; LEAF_SIZE, 8, patches per leaf
- NUM_QUERIES, 1024, query patches to load
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse, begin a load (accepted only in IDLE/DONE)
- in_data  in  FETCH_WIDTH*DATA_WIDTH  aggregator receiver_data
- in_enq  in  1  aggregator receiver_enq
- in_full_n  out  1  to aggregator receiver_full_n; high = may pack
- agg_change_fetch_width  out  1  to aggregator change_fetch_width
- agg_fetch_width  out  3  to aggregator input_fetch_width
- node_wen / node_addr / node_wdata  out  1 / clog2(NUM_NODES) / NODE_FW*DATA_WIDTH
- leaf_wen / leaf_addr / leaf_slot / leaf_wdata  out  1 / clog2(NUM_LEAVES) / clog2(LEAF_SIZE) / PATCH_FW*DATA_WIDTH
- query_wen / query_addr / query_wdata  out  1 / clog2(NUM_QUERIES) / PATCH_FW*DATA_WIDTH
- busy  out  1  high from start acceptance until DONE
- done  out  1  high while in DONE

## Operation
- States: IDLE, SW_NODE, NODES, SW_LEAF, LEAVES, SW_QUERY, QUERIES, DONE.
- IDLE: in_full_n=0. start -> SW_NODE. DONE: in_full_n=0, done=1. start -> SW_NODE (full reload), counters cleared.
- SW_x (exactly 1 cycle): agg_change_fetch_width=1, agg_fetch_width=NODE_FW (SW_NODE) or PATCH_FW (SW_LEAF, SW_QUERY), in_full_n=0; then go to the matching load state.
- Load states: in_full_n=1 except in the accept cycle of the phase's last element, where it is combinationally 0 (in_full_n = in_load_state && !(in_enq && last)). This prevents the aggregator dequeuing a narrow word under the old width.
- Each in_enq in a load state writes one element. Inputs in_data[NODE_FW*DATA_WIDTH-1:0] (nodes) or [PATCH_FW*DATA_WIDTH-1:0] (patches); upper bits ignored.
- NODES: node_addr = node count 0..NUM_NODES-1; last -> SW_LEAF.
- LEAVES: leaf_slot counts 0..LEAF_SIZE-1, wraps to 0 and leaf_addr increments; last = leaf NUM_LEAVES-1, slot LEAF_SIZE-1 -> SW_QUERY.
- QUERIES: query_addr 0..NUM_QUERIES-1; last -> DONE.
- in_enq outside load states is a protocol error: ignored, no write.
- Memories always accept writes; the block never back-pressures for memory.
- start while busy is ignored.

## Timing
- Reset: state IDLE, all counters 0, all *_wen 0, all addr/slot/wdata 0, agg_change_fetch_width 0, agg_fetch_width 0, in_full_n 0, busy 0, done 0.
- Write latency 1: in_enq at cycle t -> *_wen=1 at t+1, with registered addr/wdata of the element accepted at t. At most one wen high per cycle.
- Phase boundary: last enq at E (in_full_n=0 at E); SW state at E+1 (change pulse, in_full_n=0); aggregator width valid from E+2; in_full_n=1 from E+2. Exactly 2 blocked cycles per boundary.
- start at t -> SW_NODE at t+1, busy=1 at t+1, in_full_n=1 at t+2.
- done/busy change the cycle after the last query is accepted, together with the last query_wen.
- Reset mid-load: next cycle is IDLE with reset values, no partial-phase state retained. The aggregator shares rst_n; widths are reprogrammed on the next start.

## Test plan
- NUM_NODES=3, NUM_LEAVES=2, LEAF_SIZE=2, NUM_QUERIES=4; start, then back-to-back in_enq. Expect node_addr 0,1,2; leaf (addr,slot) (0,0),(0,1),(1,0),(1,1); query_addr 0..3; done=1 one cycle after the 4th query enq.
- Check agg_change_fetch_width pulses exactly 3 times, with width 2, 5, 5. At each boundary in_full_n is low for exactly 2 cycles.
- Drive in_enq on the cycle after the last node enq with in_full_n=0. Expect no write and the pulse is still issued. A second enq in the SW cycle is also ignored.
- Random gaps between enqs (0-5 cycles): written data equals in_data at enq time, bits 0x0001_0002 -> node_wdata 0x0001_0002, wen exactly 1 cycle after.
- Assert rst_n=0 for 1 cycle midway through LEAVES. Expect reset values next cycle, no wen, in_full_n=0. A new start reloads from node_addr 0.
- start pulses during NODES are ignored. start in DONE restarts, clearing done at t+1.
